tmul: RTL and testbench
=======================

Name: tmul

Overview:
- Pipelined floating-point multiplier, same number format and AXI-stream-style port set as `tadd`.
- Sits directly upstream of `tadd` in the MAC datapath: `m_axis_result` feeds a `tadd` operand channel.
- Throughput one product per cycle, fixed 3-cycle latency.
- Adds output backpressure (`m_axis_result_tready`) so `tadd`-side stalls propagate upstream.

Parameters:
- EXP, 5: exponent width; bias = 2^(EXP-1)-1.
- FRA, 10: stored fraction width; word width W = EXP+FRA+1.

Ports:
- aclk  in  1  clock; all state changes on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_a_tdata  in  W  operand A {sign, exp, frac}.
- s_axis_a_tvalid  in  1  A valid.
- s_axis_a_tready  out  1  A accepted when high with tvalid.
- s_axis_b_tdata  in  W  operand B.
- s_axis_b_tvalid  in  1  B valid.
- s_axis_b_tready  out  1  B accepted.
- m_axis_result_tdata  out  W  product.
- m_axis_result_tvalid  out  1  result valid.
- m_axis_result_tready  in  1  downstream accepts.
- flag  out  3  [0] overflow, [1] underflow, [2] invalid; qualified by m_axis_result_tvalid.

Behaviour:
- Reset (async assert, sync release): all stage valids = 0; m_axis_result_tdata = 0, m_axis_result_tvalid = 0, flag = 0.
- stall = m_axis_result_tvalid & ~m_axis_result_tready.
- s_axis_a_tready = s_axis_b_tready = ~stall & aresetn.
- Operand pair consumed only when a_tvalid & b_tvalid & ~stall; a lone valid is not consumed and is held by the source.
- Pipeline, all stages freeze together on stall:
  - S1: unpack, classify each operand (zero / inf / NaN / normal), sign = sA^sB, exp sum eA+eB-bias in EXP+2-bit signed, (FRA+1)x(FRA+1) mantissa product.
  - S2: normalize (product >= 2 -> shift right 1, exp+1), round-to-nearest-even on guard/round/sticky; rounding carry-out renormalizes and increments exp.
  - S3: overflow/underflow/special selection, pack into output register.
- Latency: the result for a pair accepted at edge N is valid after edge N+3, absent stalls; bubbles propagate as invalid stages.
- Output holds tdata/flag/tvalid stable while stall.
- Subnormal inputs (exp = 0) are treated as signed zero, with no flag.
- Results with final biased exp <= 0 flush to signed zero, flag[1] = 1.
- Final biased exp >= 2^EXP-1 produces signed Inf, flag[0] = 1.
- Special cases, in priority order:
  - Any NaN input, or Inf x 0: canonical NaN {0, all-ones exp, frac MSB = 1, rest 0}, flag[2] = 1.
  - Inf x nonzero: signed Inf, no flag.
  - Zero x finite: signed zero, no flag.
- Only one flag bit is set per result.
- Reset mid-operation discards all in-flight data; no result is emitted for pairs accepted before reset.

Test Plan:
- Basic product: A = 16'h3C00, B = 16'h4000 -> 16'h4000, flag 0, tvalid exactly 3 cycles after acceptance.
- Rounding: A = 16'h2E66, B = 16'h3266 -> 16'h251E; A = 16'h3E00, B = 16'h3E00 -> 16'h4080.
- Sign and specials:
  - 16'hBC00 x 16'h4000 -> 16'hC000.
  - 16'h7C00 x 16'h0000 -> 16'h7E00, flag = 3'b100.
  - 16'h7E00 x 16'h3C00 -> 16'h7E00, flag = 3'b100.
- Range limits:
  - 16'h7BFF x 16'h7BFF -> 16'h7C00, flag = 3'b001.
  - 16'h0400 x 16'h0400 -> 16'h0000, flag = 3'b010.
- Streaming with backpressure:
  - Drive 8 back-to-back pairs; hold m_axis_result_tready = 0 for 4 cycles mid-stream.
  - Expect s_axis_*_tready low during the stall and output held stable.
  - All 8 results arrive in order with none lost or duplicated.
- Handshake and reset:
  - Only a_tvalid high -> no acceptance, no output.
  - Assert aresetn = 0 with 2 pairs in flight -> outputs clear immediately, and no stale result appears after release.

Source files
------------

// File: rtl/tmul.sv
// Three-stage pipelined floating-point multiplier with AXI-stream style handshakes.
// Operands are registered on acceptance, then multiplied, rounded and packed.
module tmul #(
  parameter int EXP = 5,
  parameter int FRA = 10
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [EXP+FRA:0]   s_axis_a_tdata,
  input  logic               s_axis_a_tvalid,
  output logic               s_axis_a_tready,
  input  logic [EXP+FRA:0]   s_axis_b_tdata,
  input  logic               s_axis_b_tvalid,
  output logic               s_axis_b_tready,
  output logic [EXP+FRA:0]   m_axis_result_tdata,
  output logic               m_axis_result_tvalid,
  input  logic               m_axis_result_tready,
  output logic [2:0]         flag
);
  localparam int W  = EXP + FRA + 1;
  localparam int M  = FRA + 1;
  localparam int P  = 2 * M;
  localparam int EW = EXP + 2;
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  logic stall, accept;

  assign stall           = m_axis_result_tvalid & ~m_axis_result_tready;
  assign accept          = s_axis_a_tvalid & s_axis_b_tvalid & ~stall;
  assign s_axis_a_tready = ~stall & aresetn;
  assign s_axis_b_tready = ~stall & aresetn;

  logic         v0_q, v0_d;
  logic [W-1:0] a0_q, a0_d, b0_q, b0_d;

  logic                 v1_q, v1_d, sign1_q, sign1_d;
  logic                 nan1_q, nan1_d, inf1_q, inf1_d, zero1_q, zero1_d;
  logic signed [EW-1:0] exp1_q, exp1_d;
  logic [P-1:0]         prod1_q, prod1_d;

  logic                 v2_q, v2_d, sign2_q, sign2_d;
  logic                 nan2_q, nan2_d, inf2_q, inf2_d, zero2_q, zero2_d;
  logic signed [EW-1:0] exp2_q, exp2_d;
  logic [FRA-1:0]       frac2_q, frac2_d;

  logic         res_valid_q, res_valid_d;
  logic [W-1:0] res_q, res_d;
  logic [2:0]   flag_q, flag_d;

  logic [EXP-1:0] ea, eb;
  logic [FRA-1:0] fa, fb;
  logic           a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  logic [P-1:0]         norm;
  logic [M-1:0]         keep;
  logic                 guard, rnd, sticky, round_up;
  logic [M:0]           rounded;
  logic signed [EW-1:0] exp_n;

  always_comb begin
    v0_d = accept;
    a0_d = s_axis_a_tdata;
    b0_d = s_axis_b_tdata;
  end

  // Subnormals (exp = 0) are classified as zero, so they never reach the mantissa path.
  always_comb begin
    ea     = a0_q[W-2:FRA];
    fa     = a0_q[FRA-1:0];
    eb     = b0_q[W-2:FRA];
    fb     = b0_q[FRA-1:0];
    a_zero = (ea == '0);
    a_inf  = (ea == '1) && (fa == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_zero = (eb == '0);
    b_inf  = (eb == '1) && (fb == '0);
    b_nan  = (eb == '1) && (fb != '0);

    v1_d    = v0_q;
    sign1_d = a0_q[W-1] ^ b0_q[W-1];
    nan1_d  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    inf1_d  = (a_inf | b_inf) & ~nan1_d;
    zero1_d = (a_zero | b_zero) & ~nan1_d & ~inf1_d;
    exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    prod1_d = {{(P-M){1'b0}}, 1'b1, fa} * {{(P-M){1'b0}}, 1'b1, fb};
  end

  // Product lies in [1,4): align the leading one to the top bit, then round to nearest even.
  always_comb begin
    norm     = prod1_q[P-1] ? prod1_q : (prod1_q << 1);
    exp_n    = exp1_q + EW'(prod1_q[P-1]);
    keep     = norm[P-1 -: M];
    guard    = norm[P-M-1];
    rnd      = norm[P-M-2];
    sticky   = |norm[P-M-3:0];
    round_up = guard & (rnd | sticky | keep[0]);
    rounded  = {1'b0, keep} + (M+1)'(round_up);

    v2_d    = v1_q;
    sign2_d = sign1_q;
    nan2_d  = nan1_q;
    inf2_d  = inf1_q;
    zero2_d = zero1_q;
    frac2_d = rounded[M] ? rounded[FRA:1] : rounded[FRA-1:0];
    exp2_d  = exp_n + EW'(rounded[M]);
  end

  always_comb begin
    res_valid_d = v2_q;
    res_d       = {sign2_q, exp2_q[EXP-1:0], frac2_q};
    flag_d      = 3'b000;
    if (nan2_q) begin
      res_d  = {1'b0, {EXP{1'b1}}, 1'b1, {(FRA-1){1'b0}}};
      flag_d = 3'b100;
    end else if (inf2_q) begin
      res_d = {sign2_q, {EXP{1'b1}}, {FRA{1'b0}}};
    end else if (zero2_q) begin
      res_d = {sign2_q, {(W-1){1'b0}}};
    end else if (exp2_q >= EMAX) begin
      res_d  = {sign2_q, {EXP{1'b1}}, {FRA{1'b0}}};
      flag_d = 3'b001;
    end else if (exp2_q <= EZERO) begin
      res_d  = {sign2_q, {(W-1){1'b0}}};
      flag_d = 3'b010;
    end
  end

  // Every stage shares the single stall enable so the pipeline freezes as a unit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v0_q        <= 1'b0;
      a0_q        <= '0;
      b0_q        <= '0;
      v1_q        <= 1'b0;
      sign1_q     <= 1'b0;
      nan1_q      <= 1'b0;
      inf1_q      <= 1'b0;
      zero1_q     <= 1'b0;
      exp1_q      <= '0;
      prod1_q     <= '0;
      v2_q        <= 1'b0;
      sign2_q     <= 1'b0;
      nan2_q      <= 1'b0;
      inf2_q      <= 1'b0;
      zero2_q     <= 1'b0;
      exp2_q      <= '0;
      frac2_q     <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      flag_q      <= 3'b000;
    end else if (!stall) begin
      v0_q <= v0_d;
      if (v0_d) begin
        a0_q <= a0_d;
        b0_q <= b0_d;
      end
      v1_q        <= v1_d;
      sign1_q     <= sign1_d;
      nan1_q      <= nan1_d;
      inf1_q      <= inf1_d;
      zero1_q     <= zero1_d;
      exp1_q      <= exp1_d;
      prod1_q     <= prod1_d;
      v2_q        <= v2_d;
      sign2_q     <= sign2_d;
      nan2_q      <= nan2_d;
      inf2_q      <= inf2_d;
      zero2_q     <= zero2_d;
      exp2_q      <= exp2_d;
      frac2_q     <= frac2_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      flag_q      <= flag_d;
    end
  end

  assign m_axis_result_tdata  = res_q;
  assign m_axis_result_tvalid = res_valid_q;
  assign flag                 = flag_q;

endmodule

// File: tb/tb_tmul.sv
// Scoreboard bench for tmul: a stimulus-side monitor queues expected products from an
// arithmetic reference model; an output monitor pops and compares on each result handshake.
module tb_tmul;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_v = 1'b0, b_v = 1'b0, a_rdy, b_rdy;
  logic [15:0] r_data;
  logic        r_v;
  logic        r_rdy = 1'b1;
  logic [2:0]  flag;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  flag;
    int          acc;
    logic        chk_lat;
  } sb_t;

  sb_t         sb[$];
  int          n_pass = 0, n_chk = 0, cycle = 0, n_out = 0, stall_seen = 0;
  bit          lat_mode = 1'b0, use_forced = 1'b0, prev_stall = 1'b0;
  logic [18:0] forced_exp = '0;
  logic [19:0] prev_out = '0;
  logic [15:0] dv_a[11], dv_b[11];
  logic [18:0] dv_e[11];

  tmul dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tdata       (a_data),
    .s_axis_a_tvalid      (a_v),
    .s_axis_a_tready      (a_rdy),
    .s_axis_b_tdata       (b_data),
    .s_axis_b_tvalid      (b_v),
    .s_axis_b_tready      (b_rdy),
    .m_axis_result_tdata  (r_data),
    .m_axis_result_tvalid (r_v),
    .m_axis_result_tready (r_rdy),
    .flag                 (flag)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Reference: exact integer product of the significands, rounded half-to-even by remainder.
  function automatic logic [18:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ea = int'(a[14:10]);
    int eb = int'(b[14:10]);
    int fa = int'(a[9:0]);
    int fb = int'(b[9:0]);
    bit s  = a[15] ^ b[15];
    bit na = (ea == 31) && (fa != 0), nb = (eb == 31) && (fb != 0);
    bit ia = (ea == 31) && (fa == 0), ib = (eb == 31) && (fb == 0);
    bit za = (ea == 0), zb = (eb == 0);
    int p, sh, e, q, rem, half;
    if (na || nb || (ia && zb) || (za && ib)) return {3'b100, 16'h7E00};
    if (ia || ib) return {3'b000, s, 5'h1F, 10'h000};
    if (za || zb) return {3'b000, s, 15'h0000};
    p    = (1024 + fa) * (1024 + fb);
    sh   = (p >= (1 << 21)) ? 11 : 10;
    e    = ea + eb - 15 + (sh - 10);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) return {3'b001, s, 5'h1F, 10'h000};
    if (e <= 0) return {3'b010, s, 15'h0000};
    return {3'b000, s, e[4:0], 10'(q - 1024)};
  endfunction

  function automatic logic [15:0] rand_op();
    int          r = $urandom_range(0, 19);
    logic [4:0]  e;
    logic [9:0]  f = 10'($urandom);
    if (r == 0) e = 5'd0;
    else if (r == 1) e = 5'd31;
    else if (r == 2) begin
      e = 5'd31;
      f = '0;
    end else if (r < 6) e = 5'($urandom_range(1, 7));
    else if (r < 9) e = 5'($urandom_range(24, 30));
    else e = 5'($urandom_range(1, 30));
    return {1'($urandom), e, f};
  endfunction

  // Output side is checked first, then new acceptances are queued for later edges.
  always @(negedge aclk) begin
    sb_t item;
    logic [18:0] ex;
    if (aresetn) begin
      if (prev_stall) check_output("hold_stable", {12'h0, r_v, flag, r_data}, {12'h0, prev_out});
      if (r_v && !r_rdy) begin
        stall_seen++;
        check_output("stall_tready", {30'h0, a_rdy, b_rdy}, 32'h0);
      end
      if (r_v && r_rdy) begin
        n_out++;
        check_output("sb_nonempty", {31'h0, sb.size() > 0}, 32'h1);
        if (sb.size() > 0) begin
          item = sb.pop_front();
          check_output("tdata", {16'h0, r_data}, {16'h0, item.data});
          check_output("flag", {29'h0, flag}, {29'h0, item.flag});
          if (item.chk_lat) check_output("latency", cycle - item.acc, 32'd3);
        end
      end
      prev_stall = r_v && !r_rdy;
      prev_out   = {r_v, flag, r_data};
      if (a_v && b_v && a_rdy) begin
        ex = use_forced ? forced_exp : ref_mul(a_data, b_data);
        sb.push_back('{data: ex[15:0], flag: ex[18:16], acc: cycle + 1, chk_lat: lat_mode});
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input int skew);
    bit done = 1'b0;
    a_data = a;
    b_data = b;
    a_v    = 1'b1;
    b_v    = (skew == 0);
    for (int k = 0; k < skew; k++) begin
      @(posedge aclk);
      #1;
    end
    b_v = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge aclk);
      done = a_rdy;
      @(posedge aclk);
      #1;
    end
    if (!done) check_output("accept_timeout", 32'h0, 32'h1);
    a_v = 1'b0;
    b_v = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 1000 && sb.size() != 0; t++) @(posedge aclk);
    #1;
    check_output("drain_empty", sb.size(), 32'h0);
  endtask

  initial begin
    int base;
    bit rnd_done;
    dv_a = '{16'h3C00, 16'h2E66, 16'h3E00, 16'hBC00, 16'h7C00, 16'h7E00,
             16'h7BFF, 16'h0400, 16'h8000, 16'hFC00, 16'h0001};
    dv_b = '{16'h4000, 16'h3266, 16'h3E00, 16'h4000, 16'h0000, 16'h3C00,
             16'h7BFF, 16'h0400, 16'h3C00, 16'h4000, 16'h3C00};
    dv_e = '{{3'b000, 16'h4000}, {3'b000, 16'h251E}, {3'b000, 16'h4080},
             {3'b000, 16'hC000}, {3'b100, 16'h7E00}, {3'b100, 16'h7E00},
             {3'b001, 16'h7C00}, {3'b010, 16'h0000}, {3'b000, 16'h8000},
             {3'b000, 16'hFC00}, {3'b000, 16'h0000}};

    #1;
    check_output("reset_out", {12'h0, r_v, flag, r_data}, 32'h0);
    check_output("reset_tready", {30'h0, a_rdy, b_rdy}, 32'h0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    lat_mode   = 1'b1;
    use_forced = 1'b1;
    for (int i = 0; i < 11; i++) begin
      forced_exp = dv_e[i];
      apply_stimulus(dv_a[i], dv_b[i], 0);
      drain();
    end
    use_forced = 1'b0;
    lat_mode   = 1'b0;

    // Eight back-to-back pairs with a four-cycle downstream stall in the middle.
    base       = n_out;
    stall_seen = 0;
    fork
      for (int i = 0; i < 8; i++) apply_stimulus(rand_op(), rand_op(), 0);
      begin
        repeat (5) @(posedge aclk);
        #1 r_rdy = 1'b0;
        repeat (4) @(posedge aclk);
        #1 r_rdy = 1'b1;
      end
    join
    drain();
    check_output("stream_count", n_out - base, 32'd8);
    check_output("stall_seen", {31'h0, stall_seen > 0}, 32'h1);

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++)
          apply_stimulus(rand_op(), rand_op(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge aclk);
        #1 r_rdy = ($urandom_range(0, 3) != 0);
      end
    join
    r_rdy = 1'b1;
    drain();

    base   = n_out;
    a_data = 16'h3C00;
    a_v    = 1'b1;
    repeat (10) @(posedge aclk);
    #1 a_v = 1'b0;
    repeat (6) @(posedge aclk);
    #1;
    check_output("lone_valid_out", n_out - base, 32'd0);
    check_output("lone_valid_sb", sb.size(), 32'd0);

    apply_stimulus(16'h3C00, 16'h4000, 0);
    apply_stimulus(16'h4200, 16'h4200, 0);
    aresetn = 1'b0;
    sb.delete();
    #1;
    check_output("midreset_out", {12'h0, r_v, flag, r_data}, 32'h0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    base = n_out;
    repeat (10) @(posedge aclk);
    #1;
    check_output("no_stale_out", n_out - base, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got %0d, expected finish", cycle);
    $fatal(1, "[TB] timeout");
  end

endmodule
